// File: rtl/bitserial_tx.sv
// bitserial_tx: producer end of the 1-bit serial REQ/ACK/DATA link.
// Buffers 8-bit host words in a FIFO and shifts each one out LSB-first
// once the consumer raises OUT_REQ. Each word is an ACK strobe with bit 0,
// then bits 1..7, then a run of idle (zero) cycles.
//
// Ports:
//   CLK, RSTB          clock (rising edge) / async active-low reset
//   WR_VALID/WR_READY  host write handshake; WR_READY is combinational !full
//   WR_DATA            word to buffer
//   OUT_REQ            consumer ready for a new word (level, sampled in IDLE)
//   OUT_ACK            registered one-cycle start strobe, coincident with bit 0
//   OUT_DATA           registered serial data, LSB first
//   FIFO_LEVEL         words currently buffered (0..FIFO_DEPTH)
//   BUSY               registered, high whenever the FSM is not IDLE
//   WORDS_SENT         completed-word counter, wraps 0xFFFF -> 0
module bitserial_tx #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                          CLK,
  input  logic                          RSTB,
  input  logic                          WR_VALID,
  output logic                          WR_READY,
  input  logic [7:0]                    WR_DATA,
  input  logic                          OUT_REQ,
  output logic                          OUT_ACK,
  output logic                          OUT_DATA,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          BUSY,
  output logic [15:0]                   WORDS_SENT
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // FIFO storage and pointers
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          full, empty, push, fifo_pop;

  // FSM and link state
  state_e        state_q, state_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [GW-1:0] gapcnt_q, gapcnt_d;
  logic          ack_q, ack_d;
  logic          data_q, data_d;
  logic          busy_q, busy_d;
  logic [15:0]   words_sent_q, words_sent_d;

  assign full  = (level_q == LW'(FIFO_DEPTH));
  assign empty = (level_q == '0);
  assign push  = WR_VALID && !full;

  assign WR_READY   = !full;
  assign FIFO_LEVEL = level_q;
  assign OUT_ACK    = ack_q;
  assign OUT_DATA   = data_q;
  assign BUSY       = busy_q;
  assign WORDS_SENT = words_sent_q;

  // Storage array carries no reset; contents are only read when level_q says valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= WR_DATA;
    end
  end

  // Pointers wrap naturally since FIFO_DEPTH is a power of two.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push, fifo_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // FSM state and link output registers
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      gapcnt_q     <= '0;
      ack_q        <= 1'b0;
      data_q       <= 1'b0;
      busy_q       <= 1'b0;
      words_sent_q <= '0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      gapcnt_q     <= gapcnt_d;
      ack_q        <= ack_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      words_sent_q <= words_sent_d;
    end
  end

  // Next-state and next-output logic; link outputs default to idle zeros.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    gapcnt_d     = gapcnt_q;
    ack_d        = 1'b0;
    data_d       = 1'b0;
    words_sent_d = words_sent_q;
    fifo_pop     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty && OUT_REQ) begin
          fifo_pop = 1'b1;
          shreg_d  = mem_q[rd_ptr_q];
          ack_d    = 1'b1;
          data_d   = mem_q[rd_ptr_q][0];
          bitcnt_d = 3'd1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // OUT_REQ is deliberately ignored: a started word always completes.
        data_d   = shreg_q[bitcnt_q];
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          words_sent_d = words_sent_q + 16'd1;
          gapcnt_d     = GW'(GAP_CYCLES);
          state_d      = GAP;
        end
      end
      GAP: begin
        // Entered while bit 7 is still on the link, so counting down from
        // GAP_CYCLES gives GAP_CYCLES+1 zero cycles before REQ is sampled.
        if (gapcnt_q == '0) begin
          state_d = IDLE;
        end else begin
          gapcnt_d = gapcnt_q - GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: doc/bitserial_tx.md
Name: bitserial_tx

Overview:
Transmitter end of the team's 1-bit serial REQ/ACK/DATA link, i.e. the producer that feeds a neuron input bundle (INx_REQ/INx_ACK/INx_DATA).
- Accepts parallel 8-bit words from a host or testbench through a valid/ready write port.
- Buffers words in a small FIFO.
- Serializes each word LSB-first onto the link whenever the consumer raises REQ.
- Used to drive the first neuron layer and as a reusable stimulus source.

Parameters:
FIFO_DEPTH, 4, number of buffered words; power of two, >= 2.
GAP_CYCLES, 1, mandatory idle cycles after bit 7 before REQ is sampled again; >= 1.

Ports:
CLK  input  1  global clock, all state on rising edge.
RSTB  input  1  global reset, asynchronous, active-low.
WR_VALID  input  1  host offers WR_DATA.
WR_READY  output  1  FIFO can accept a word; equals !full.
WR_DATA  input  8  word to transmit.
OUT_REQ  input  1  consumer ready for a new word (level).
OUT_ACK  output  1  one-cycle start strobe, coincident with bit 0.
OUT_DATA  output  1  serial data, LSB first.
FIFO_LEVEL  output  $clog2(FIFO_DEPTH)+1  words currently buffered.
BUSY  output  1  high in any state other than IDLE.
WORDS_SENT  output  16  count of completed words; wraps 0xFFFF->0.

Behaviour:
- Reset (RSTB low, async): FSM=IDLE; FIFO empty; OUT_ACK=0; OUT_DATA=0; BUSY=0; WORDS_SENT=0; FIFO_LEVEL=0. WR_READY=1 during and after reset. Any in-flight word is dropped; ACK/DATA go low immediately, not at the next edge.
- FIFO write: on an edge where WR_VALID && WR_READY, push WR_DATA. There is no bypass, so a word written at edge E is visible to the FSM at edge E+1 at the earliest. WR_READY is combinational !full, so a pop in the same cycle does not raise it.
- Simultaneous push and pop: both take effect; FIFO_LEVEL is unchanged.
- Link registers: OUT_ACK, OUT_DATA and BUSY are registered outputs.
- FSM states: IDLE, SHIFT, GAP.
- IDLE, start condition: at an edge where FIFO is non-empty and OUT_REQ==1:
  - pop head into the 8-bit shift register;
  - drive OUT_ACK<=1, OUT_DATA<=head[0], bitcnt<=1;
  - go to SHIFT.
- IDLE, otherwise: OUT_ACK=0, OUT_DATA=0; stay in IDLE.
- SHIFT: each edge drives OUT_ACK<=0 and OUT_DATA<=shreg[bitcnt], then increments bitcnt.
  - On the edge that drives bit 7: WORDS_SENT<=WORDS_SENT+1, load gapcnt, go to GAP.
  - OUT_REQ is ignored in SHIFT. A consumer dropping REQ after ACK is expected, and a word is never aborted except by reset.
- GAP: OUT_DATA<=0, OUT_ACK<=0 for GAP_CYCLES cycles, then go to IDLE. REQ is not sampled in GAP.
- Latency: start edge E0 gives ACK=1/bit0 after E0; bits 1..7 follow after E1..E7; GAP begins after E8.
- Throughput: back-to-back word period is 9+GAP_CYCLES cycles (10 at default).
- Consumer compatibility: a consumer that holds REQ high continuously receives back-to-back words separated by GAP_CYCLES+1 zero cycles. A consumer that lowers REQ after ACK and re-raises it later receives the next word on the edge after REQ is seen high in IDLE.
- FIFO full with REQ low: WR_READY=0; WR_DATA is not accepted; the host must hold it.
- Empty FIFO with REQ high: stay in IDLE; link outputs stay 0.
- Pointer wrap: FIFO pointers wrap modulo FIFO_DEPTH; FIFO_LEVEL counts 0..FIFO_DEPTH inclusive.

Test Plan:
1. Single word: reset, push 0xA5, OUT_REQ=1 -> ACK high exactly one cycle with DATA=1, then DATA 0,1,0,0,1,0,1; WORDS_SENT=1; FIFO_LEVEL 1->0 at the start edge.
2. Back-to-back: push 0x01,0x80,0xFF, OUT_REQ held 1 -> three ACK pulses 10 cycles apart; serial streams 10000000, 00000001, 11111111; WORDS_SENT=3.
3. Full/backpressure: OUT_REQ=0, push 5 words 0x10..0x14 -> WR_READY low after the 4th and FIFO_LEVEL=4. Then raise REQ -> 0x10 starts, WR_READY returns high the following cycle, 0x14 accepted. All 5 words are transmitted in order.
4. REQ handshake as a neuron consumer: REQ drops the cycle after ACK and re-raises 3 cycles after bit 7 -> next ACK occurs the edge after REQ is sampled high in IDLE; no ACK while REQ is low.
5. Reset mid-word: assert RSTB low while bit 4 of 0x3C is on the link -> ACK/DATA/BUSY go to 0 asynchronously; FIFO_LEVEL=0; WORDS_SENT=0; WR_READY=1. After release with no writes, link stays idle.
6. Counter wrap: force WORDS_SENT to 0xFFFF via 65535 sends (or a fast-forward bench) and send one more word -> WORDS_SENT=0x0000.
